// File: rtl/lcd_host_pkg.sv
// Shared constants, state encoding and window-address helper for the LCD host driver.
package lcd_pkg;

  localparam logic [2:0] CMD_REFLASH = 3'd0;
  localparam logic [2:0] CMD_LOAD    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;

  localparam int IMG_W    = 6;
  localparam int IMG_SIZE = 36;
  localparam int WIN      = 3;
  localparam int ORG_MAX  = 3;
  localparam int LOAD_ORG = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM,
    ST_COLLECT,
    ST_DONE
  } host_state_t;

  // Image index of window byte j (row-major inside the 3x3 window) for origin (row, col).
  function automatic logic [5:0] win_addr(input logic [1:0] row, input logic [1:0] col,
                                          input logic [3:0] j);
    logic [3:0] jr, jc;
    logic [5:0] r6;
    jr = j / 4'd3;
    jc = j % 4'd3;
    r6 = {4'b0, row} + {2'b0, jr};
    return r6 * 6'(IMG_W) + {4'b0, col} + {2'b0, jc};
  endfunction

endpackage

// File: rtl/lcd_host_if.sv
// Host <-> LCD window controller bus: command strobe, pixel stream and window beats.
interface lcd_host_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;

  modport master (output cmd, cmd_valid, datain, input busy, dataout, output_valid);
  modport slave  (input cmd, cmd_valid, datain, output busy, dataout, output_valid);
endinterface

// File: rtl/lcd_host_origin.sv
// Mirror of the controller's window origin; yields the image index expected for each beat.
module lcd_host_origin
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_upd,
  input  logic [2:0] i_cmd,
  input  logic [3:0] i_beat,
  output logic [5:0] o_exp_addr
);

  logic [1:0] r_row, r_col;

  // Moves that would leave the 0..ORG_MAX range are silently ignored, as the controller does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= 2'(LOAD_ORG);
      r_col <= 2'(LOAD_ORG);
    end else if (i_upd) begin
      case (i_cmd)
        CMD_LOAD: begin
          r_row <= 2'(LOAD_ORG);
          r_col <= 2'(LOAD_ORG);
        end
        CMD_RIGHT: if (r_col != 2'(ORG_MAX)) r_col <= r_col + 2'd1;
        CMD_LEFT:  if (r_col != 2'd0)        r_col <= r_col - 2'd1;
        CMD_UP:    if (r_row != 2'd0)        r_row <= r_row - 2'd1;
        CMD_DOWN:  if (r_row != 2'(ORG_MAX)) r_row <= r_row + 2'd1;
        default: ;
      endcase
    end
  end

  assign o_exp_addr = win_addr(r_row, r_col, i_beat);

endmodule

// File: rtl/lcd_host.sv
// LCD host driver: image store, command sequencing, window collection and byte checking.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_we,
  input  logic [5:0]  img_addr,
  input  logic [7:0]  img_wdata,
  input  logic        req_valid,
  input  logic [2:0]  req_cmd,
  output logic        req_ready,
  lcd_host_if.master  ctrl,
  output logic        win_valid,
  output logic [71:0] win_data,
  output logic        mismatch,
  output logic        err_timeout,
  input  logic        clr_err
);

  // Wide enough to hold a full STREAM count plus the COLLECT limit.
  localparam int TW = $clog2(TIMEOUT + IMG_SIZE + 2);

  host_state_t r_state, w_next;

  logic [7:0]    r_img [IMG_SIZE];
  logic [2:0]    r_cmd;
  logic          r_loaded;
  logic [5:0]    r_k;
  logic [3:0]    r_beat;
  logic [TW-1:0] r_to;
  logic [63:0]   r_buf;
  logic [71:0]   r_win;
  logic          r_mis, r_tmo;

  logic          w_accept, w_cmd_fire, w_beat, w_tmo_hit, w_last_beat, w_stream_end;
  logic          w_ready, w_win_valid;
  logic [7:0]    w_datain;
  logic [5:0]    w_exp_addr;

  // Commands other than load need a loaded image; codes above DOWN are never valid.
  assign w_accept = req_valid && (r_state == ST_IDLE) &&
                    ((req_cmd == CMD_LOAD) || (r_loaded && req_cmd <= CMD_DOWN));

  assign w_beat       = (r_state == ST_COLLECT) && ctrl.output_valid;
  assign w_last_beat  = w_beat && (r_beat == 4'(WIN * WIN - 1));
  assign w_tmo_hit    = (r_state == ST_COLLECT) && !ctrl.output_valid && (r_to >= TW'(TIMEOUT));
  assign w_stream_end = (r_state == ST_STREAM) && (r_k == 6'(IMG_SIZE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_cmd_fire  = 1'b0;
    w_datain    = 8'd0;
    w_win_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!ctrl.busy) begin
          w_cmd_fire = 1'b1;
          w_next     = (r_cmd == CMD_LOAD) ? ST_STREAM : ST_COLLECT;
        end
      end
      ST_STREAM: begin
        w_datain = r_img[r_k];
        if (w_stream_end) w_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_last_beat)    w_next = ST_DONE;
        else if (w_tmo_hit) w_next = ST_IDLE;
      end
      ST_DONE: begin
        w_win_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd    <= CMD_REFLASH;
      r_loaded <= 1'b0;
      r_k      <= 6'd0;
      r_beat   <= 4'd0;
      r_to     <= '0;
      r_buf    <= 64'd0;
      r_win    <= 72'd0;
      r_mis    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      if (w_accept) r_cmd <= req_cmd;

      if (r_state == ST_STREAM && !w_stream_end) r_k <= r_k + 6'd1;
      else                                       r_k <= 6'd0;
      if (w_stream_end) r_loaded <= 1'b1;

      if (w_cmd_fire || w_beat)                               r_to <= '0;
      else if (r_state == ST_STREAM || r_state == ST_COLLECT) r_to <= r_to + TW'(1);

      if (r_state != ST_COLLECT || w_last_beat) r_beat <= 4'd0;
      else if (w_beat)                          r_beat <= r_beat + 4'd1;

      // The published window only changes when a full set of nine beats is in.
      if (w_last_beat)  r_win <= {ctrl.dataout, r_buf};
      else if (w_beat)  r_buf[{r_beat[2:0], 3'b000} +: 8] <= ctrl.dataout;

      if (w_beat && ctrl.dataout != r_img[w_exp_addr]) r_mis <= 1'b1;
      else if (clr_err)                                r_mis <= 1'b0;

      if (w_tmo_hit)    r_tmo <= 1'b1;
      else if (clr_err) r_tmo <= 1'b0;
    end
  end

  // Image RAM carries no reset.
  always_ff @(posedge clk) begin
    if (img_we && r_state == ST_IDLE && img_addr < 6'(IMG_SIZE))
      r_img[img_addr] <= img_wdata;
  end

  lcd_host_origin u_origin (
    .clk        (clk),
    .reset      (reset),
    .i_upd      (w_cmd_fire),
    .i_cmd      (r_cmd),
    .i_beat     (r_beat),
    .o_exp_addr (w_exp_addr)
  );

  assign req_ready      = w_ready;
  assign ctrl.cmd       = r_cmd;
  assign ctrl.cmd_valid = w_cmd_fire;
  assign ctrl.datain    = w_datain;
  assign win_valid      = w_win_valid;
  assign win_data       = r_win;
  assign mismatch       = r_mis;
  assign err_timeout    = r_tmo;

endmodule
